// File: rtl/cla_irl_arb.sv
// Weighted round-robin scheduler: pops per-source CLA IRL metadata FIFOs into one registered valid/ready output.
// Optional build macro CLA_IRL_ARB_STATS_EN adds per-requester saturating grant counters with a clear input.

package cla_irl_arb_pkg;
  typedef struct packed {
    logic [7:0]  src_tag;
    logic [15:0] ctx;
    logic [7:0]  seq;
  } cla_irl_meta_type;
endpackage

module cla_irl_arb
  import cla_irl_arb_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int REQ_NBITS    = 2,
  parameter int WEIGHT_NBITS = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_REQ-1:0]                  fifo_empty,
  input  cla_irl_meta_type [NUM_REQ-1:0]      fifo_dout,
  output logic [NUM_REQ-1:0]                  fifo_rd,
  input  logic [NUM_REQ-1:0]                  req_en,
  input  logic [WEIGHT_NBITS*NUM_REQ-1:0]     req_weight,
  output logic                                out_valid,
  input  logic                                out_ready,
  output cla_irl_meta_type                    out_meta,
  output logic [REQ_NBITS-1:0]                out_src,
  output logic                                busy
`ifdef CLA_IRL_ARB_STATS_EN
  ,
  input  logic                                stats_clr,
  output logic [NUM_REQ-1:0][31:0]            grant_cnt
`endif
);

  localparam int IW = REQ_NBITS + 1;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [REQ_NBITS-1:0]    rr_ptr, rr_ptr_d;
  logic [REQ_NBITS-1:0]    grant_id, grant_id_d;
  logic [REQ_NBITS-1:0]    pick, pop_id;
  logic [WEIGHT_NBITS-1:0] burst_cnt, burst_cnt_d;
  logic [WEIGHT_NBITS-1:0] pick_weight;
  logic [WEIGHT_NBITS-1:0] weight [NUM_REQ];
  logic                    bubble, bubble_d;
  logic                    pick_valid;
  logic                    pop;
  logic                    accept;
  logic [NUM_REQ-1:0]      eligible;

  function automatic logic [REQ_NBITS-1:0] next_idx(input logic [REQ_NBITS-1:0] id);
    return (id == REQ_NBITS'(NUM_REQ - 1)) ? '0 : id + REQ_NBITS'(1);
  endfunction

  assign eligible = req_en & ~fifo_empty;
  assign accept   = ~out_valid | out_ready;
  assign busy     = (state_q == GRANT) | out_valid;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      weight[i] = req_weight[i*WEIGHT_NBITS +: WEIGHT_NBITS];
    end
  end

  // Rotate-then-priority: scanning downward lets the lowest offset from rr_ptr win.
  always_comb begin
    logic [IW-1:0] idx;
    idx        = '0;
    pick       = '0;
    pick_valid = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = {1'b0, rr_ptr} + IW'(k);
      if (idx >= IW'(NUM_REQ)) idx = idx - IW'(NUM_REQ);
      if (eligible[idx[REQ_NBITS-1:0]]) begin
        pick       = idx[REQ_NBITS-1:0];
        pick_valid = 1'b1;
      end
    end
  end

  assign pick_weight = weight[pick];

  // Every release sets bubble, so the cycle after a release never picks.
  always_comb begin
    state_d     = state_q;
    grant_id_d  = grant_id;
    burst_cnt_d = burst_cnt;
    rr_ptr_d    = rr_ptr;
    bubble_d    = 1'b0;
    pop         = 1'b0;
    pop_id      = grant_id;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (!bubble && pick_valid && accept) begin
            pop        = 1'b1;
            pop_id     = pick;
            grant_id_d = pick;
            if (pick_weight <= WEIGHT_NBITS'(1)) begin
              burst_cnt_d = '0;
              rr_ptr_d    = next_idx(pick);
              bubble_d    = 1'b1;
            end else begin
              burst_cnt_d = pick_weight - WEIGHT_NBITS'(1);
              state_d     = GRANT;
            end
          end
        end
        GRANT: begin
          if (!eligible[grant_id]) begin
            rr_ptr_d = next_idx(grant_id);
            state_d  = IDLE;
            bubble_d = 1'b1;
          end else if (accept) begin
            pop         = 1'b1;
            burst_cnt_d = burst_cnt - WEIGHT_NBITS'(1);
            if (burst_cnt == WEIGHT_NBITS'(1)) begin
              rr_ptr_d = next_idx(grant_id);
              state_d  = IDLE;
              bubble_d = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rr_ptr    <= '0;
      grant_id  <= '0;
      burst_cnt <= '0;
      bubble    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr    <= rr_ptr_d;
      grant_id  <= grant_id_d;
      burst_cnt <= burst_cnt_d;
      bubble    <= bubble_d;
    end
  end

  always_comb begin
    fifo_rd = '0;
    if (pop) fifo_rd[pop_id] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_meta  <= '0;
      out_src   <= '0;
    end else if (pop) begin
      out_valid <= 1'b1;
      out_meta  <= fifo_dout[pop_id];
      out_src   <= pop_id;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef CLA_IRL_ARB_STATS_EN
  // A clear wins over a coincident pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (stats_clr) begin
          grant_cnt[i] <= '0;
        end else if (fifo_rd[i] && (grant_cnt[i] != '1)) begin
          grant_cnt[i] <= grant_cnt[i] + 32'd1;
        end
      end
    end
  end
`endif

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert ($onehot0(fifo_rd)) else $error("ERROR cla_irl_arb: fifo_rd not one-hot-or-zero %b", fifo_rd);
      assert ((fifo_rd & fifo_empty) == '0) else $error("ERROR cla_irl_arb: fifo_rd %b on empty %b", fifo_rd, fifo_empty);
    end
  end
`endif

endmodule

// File: tb/tb_cla_irl_arb.sv
// Bench for cla_irl_arb: queue-based FIFO models feed the DUT; an abstract grant-order model predicts the output stream.
// Build with CLA_IRL_ARB_STATS_EN to also exercise the grant counters.

module tb_cla_irl_arb;
  import cla_irl_arb_pkg::*;

  localparam int N  = 4;
  localparam int RB = 2;
  localparam int WB = 4;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic [N-1:0]            fifo_empty;
  cla_irl_meta_type [N-1:0] fifo_dout;
  logic [N-1:0]            fifo_rd;
  logic [N-1:0]            req_en;
  logic [WB*N-1:0]         req_weight;
  logic                    out_valid;
  logic                    out_ready;
  cla_irl_meta_type        out_meta;
  logic [RB-1:0]           out_src;
  logic                    busy;
`ifdef CLA_IRL_ARB_STATS_EN
  logic                    stats_clr;
  logic [N-1:0][31:0]      grant_cnt;
`endif

  always #5 clk = ~clk;

  cla_irl_arb #(.NUM_REQ(N), .REQ_NBITS(RB), .WEIGHT_NBITS(WB)) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout), .fifo_rd(fifo_rd),
    .req_en(req_en), .req_weight(req_weight), .out_valid(out_valid), .out_ready(out_ready),
    .out_meta(out_meta), .out_src(out_src), .busy(busy)
`ifdef CLA_IRL_ARB_STATS_EN
    , .stats_clr(stats_clr), .grant_cnt(grant_cnt)
`endif
  );

  cla_irl_meta_type q  [N][$];
  cla_irl_meta_type mq [N][$];
  int               got_src[$], exp_src[$];
  cla_irl_meta_type got_meta[$], exp_meta[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int pop_total = 0;

  logic [N-1:0]     s_rd, s_empty;
  logic             s_valid, s_busy, s_xfer;
  logic [RB-1:0]    s_src;
  cla_irl_meta_type s_meta;
  logic             p_valid;
  int               p_id;
  cla_irl_meta_type p_meta;

  task automatic refresh();
    for (int i = 0; i < N; i++) begin
      fifo_empty[i] = (q[i].size() == 0);
      fifo_dout[i]  = (q[i].size() != 0) ? q[i][0] : '0;
    end
  endtask

  // One clock: sample DUT at the falling edge, then apply pops/handshakes after the rising edge.
  task automatic tick();
    @(negedge clk);
    s_rd = fifo_rd; s_empty = fifo_empty; s_valid = out_valid; s_src = out_src;
    s_meta = out_meta; s_busy = busy; s_xfer = out_valid & out_ready;
    @(posedge clk);
    #1;
    cyc++;
    p_valid = 1'b0;
    if (s_xfer) begin
      got_src.push_back(int'(s_src));
      got_meta.push_back(s_meta);
    end
    for (int i = 0; i < N; i++) begin
      if (s_rd[i] && q[i].size() != 0) begin
        p_valid = 1'b1; p_id = i; p_meta = q[i].pop_front(); pop_total++;
      end
    end
    refresh();
  endtask

  task automatic set_weight(input int i, input int w);
    req_weight[i*WB +: WB] = WB'(w);
  endtask

  task automatic fill(input int i, input int n);
    repeat (n) q[i].push_back(cla_irl_meta_type'($urandom));
    refresh();
  endtask

  task automatic do_reset();
    for (int i = 0; i < N; i++) q[i].delete();
    refresh();
    rst = 1'b1; req_en = '1; req_weight = '0; out_ready = 1'b1;
`ifdef CLA_IRL_ARB_STATS_EN
    stats_clr = 1'b0;
`endif
    tick(); tick();
    rst = 1'b0;
    got_src.delete(); got_meta.delete(); exp_src.delete(); exp_meta.delete();
    pop_total = 0;
  endtask

  // Grant-order model: from the pointer, the first enabled non-empty source gets min(weight,len) pops.
  task automatic run_model(input int ptr0, input logic [N-1:0] en);
    int ptr, found, n;
    for (int i = 0; i < N; i++) mq[i] = q[i];
    ptr = ptr0;
    for (int guard = 0; guard < 1000; guard++) begin
      found = -1;
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (ptr + k) % N;
        if (found < 0 && en[idx] && mq[idx].size() != 0) found = idx;
      end
      if (found < 0) break;
      n = int'(req_weight[found*WB +: WB]);
      if (n == 0) n = 1;
      for (int j = 0; j < n && mq[found].size() != 0; j++) begin
        exp_src.push_back(found);
        exp_meta.push_back(mq[found].pop_front());
      end
      ptr = (found + 1) % N;
    end
  endtask

  task automatic drain(input int budget, output bit timed_out);
    int c;
    c = 0;
    while (c < budget && got_src.size() < exp_src.size()) begin
      tick(); c++;
    end
    timed_out = (got_src.size() < exp_src.size());
    repeat (4) tick();
  endtask

  task automatic test_reset();
    for (int i = 0; i < N; i++) q[i].delete();
    req_en = '1; req_weight = '0; out_ready = 1'b1; rst = 1'b1;
`ifdef CLA_IRL_ARB_STATS_EN
    stats_clr = 1'b0;
`endif
    fill(0, 2);
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++;
      if (s_rd !== '0) begin n_fail++; $display("FAIL reset_rd_gate: got %b want 0", s_rd); end
    end
    q[0].delete(); refresh();
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      n_checks++;
      if (s_rd !== '0 || s_valid !== 1'b0 || s_busy !== 1'b0) begin
        n_fail++; $display("FAIL reset_idle[%0d]: rd=%b valid=%b busy=%b want 0/0/0", c, s_rd, s_valid, s_busy);
      end
      if (c == 0) begin
        n_checks++;
        if (s_src !== '0 || s_meta !== '0) begin
          n_fail++; $display("FAIL reset_out: src=%0d meta=%h want 0/0", s_src, s_meta);
        end
      end
    end
  endtask

  task automatic test_round_robin();
    bit to;
    do_reset();
    for (int i = 0; i < N; i++) begin set_weight(i, 1); fill(i, 3); end
    run_model(0, 4'b1111);
    drain(200, to);
    n_checks++;
    if (to || got_src.size() != 12) begin n_fail++; $display("FAIL rr_count: got %0d want 12", got_src.size()); end
    for (int j = 0; j < got_src.size() && j < exp_src.size(); j++) begin
      n_checks++;
      if (got_src[j] !== (j % 4) || got_meta[j] !== exp_meta[j]) begin
        n_fail++; $display("FAIL rr_order[%0d]: got src=%0d meta=%h want src=%0d meta=%h", j, got_src[j], got_meta[j], j % 4, exp_meta[j]);
      end
    end
  endtask

  task automatic test_weighted();
    bit to;
    int tbl[16] = '{0,0,0,0,2,2,0,0,0,0,2,2,2,2,2,2};
    do_reset();
    set_weight(0, 4); set_weight(2, 2);
    fill(0, 8); fill(2, 8);
    run_model(0, 4'b1111);
    drain(300, to);
    n_checks++;
    if (to || got_src.size() != 16) begin n_fail++; $display("FAIL wrr_count: got %0d want 16", got_src.size()); end
    for (int j = 0; j < got_src.size() && j < 16; j++) begin
      n_checks++;
      if (got_src[j] !== tbl[j] || got_meta[j] !== exp_meta[j]) begin
        n_fail++; $display("FAIL wrr_order[%0d]: got src=%0d meta=%h want src=%0d meta=%h", j, got_src[j], got_meta[j], tbl[j], exp_meta[j]);
      end
    end
  endtask

  task automatic test_stall();
    bit to;
    int c;
    cla_irl_meta_type m0;
    do_reset();
    set_weight(0, 4);
    out_ready = 1'b0;
    fill(0, 4);
    for (int j = 0; j < 4; j++) begin exp_src.push_back(0); exp_meta.push_back(q[0][j]); end
    c = 0; s_valid = 1'b0;
    while (c < 20 && s_valid !== 1'b1) begin tick(); c++; end
    n_checks++;
    if (s_valid !== 1'b1) begin n_fail++; $display("FAIL stall_first: out_valid=%b want 1", s_valid); end
    m0 = exp_meta[0];
    for (int k = 0; k < 5; k++) begin
      tick();
      n_checks++;
      if (s_valid !== 1'b1 || s_meta !== m0 || s_src !== '0 || s_rd !== '0) begin
        n_fail++; $display("FAIL stall_hold[%0d]: valid=%b meta=%h src=%0d rd=%b want 1/%h/0/0", k, s_valid, s_meta, s_src, s_rd, m0);
      end
    end
    n_checks++;
    if (pop_total != 1) begin n_fail++; $display("FAIL stall_pops: got %0d want 1", pop_total); end
    out_ready = 1'b1;
    drain(100, to);
    n_checks++;
    if (to || got_src.size() != 4) begin n_fail++; $display("FAIL stall_count: got %0d want 4", got_src.size()); end
    for (int j = 0; j < got_src.size() && j < 4; j++) begin
      n_checks++;
      if (got_src[j] !== 0 || got_meta[j] !== exp_meta[j]) begin
        n_fail++; $display("FAIL stall_order[%0d]: got src=%0d meta=%h want 0/%h", j, got_src[j], got_meta[j], exp_meta[j]);
      end
    end
  endtask

  task automatic test_en_drop();
    bit to;
    int n1, bad1, c;
    do_reset();
    req_en = 4'b1110;
    for (int i = 0; i < N; i++) set_weight(i, 1);
    set_weight(1, 8);
    fill(1, 8); fill(0, 2); fill(2, 3); fill(3, 2);
    exp_src.push_back(1); exp_meta.push_back(q[1][0]);
    exp_src.push_back(1); exp_meta.push_back(q[1][1]);
    n1 = 0; c = 0;
    while (c < 50 && n1 < 2) begin tick(); c++; if (s_rd[1]) n1++; end
    n_checks++;
    if (n1 != 2) begin n_fail++; $display("FAIL drop_prefix: got %0d pops of 1 want 2", n1); end
    req_en = 4'b1101;
    run_model(2, 4'b1101);
    bad1 = 0; c = 0;
    while (c < 200 && got_src.size() < exp_src.size()) begin tick(); c++; if (s_rd[1]) bad1++; end
    to = (got_src.size() < exp_src.size());
    repeat (4) begin tick(); if (s_rd[1]) bad1++; end
    n_checks++;
    if (bad1 != 0) begin n_fail++; $display("FAIL drop_no_rd1: got %0d pops want 0", bad1); end
    n_checks++;
    if (to || got_src.size() != exp_src.size()) begin n_fail++; $display("FAIL drop_count: got %0d want %0d", got_src.size(), exp_src.size()); end
    for (int j = 0; j < got_src.size() && j < exp_src.size(); j++) begin
      n_checks++;
      if (got_src[j] !== exp_src[j] || got_meta[j] !== exp_meta[j]) begin
        n_fail++; $display("FAIL drop_order[%0d]: got src=%0d meta=%h want src=%0d meta=%h", j, got_src[j], got_meta[j], exp_src[j], exp_meta[j]);
      end
    end
  endtask

  task automatic test_weight0();
    int pcyc[$];
    int c;
    // Weight 0 on requester 3 behaves as weight 1: single pops, two cycles apart.
    do_reset();
    set_weight(3, 0);
    fill(3, 2);
    c = 0;
    while (c < 40 && pcyc.size() < 2) begin tick(); c++; if (s_rd[3]) pcyc.push_back(cyc); end
    n_checks++;
    if (pcyc.size() != 2) begin n_fail++; $display("FAIL w0_pops: got %0d want 2", pcyc.size()); end
    else begin
      n_checks++;
      if (pcyc[1] - pcyc[0] != 2) begin n_fail++; $display("FAIL w0_gap: got %0d want 2", pcyc[1] - pcyc[0]); end
    end
    repeat (4) tick();
`ifdef CLA_IRL_ARB_STATS_EN
    n_checks++;
    if (grant_cnt[3] !== 32'd2) begin n_fail++; $display("FAIL stats_cnt3: got %0d want 2", grant_cnt[3]); end
    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
    n_checks++;
    if (grant_cnt[3] !== 32'd0) begin n_fail++; $display("FAIL stats_clr3: got %0d want 0", grant_cnt[3]); end
`endif
    // Single weight-1 requester: one pop every other cycle.
    do_reset();
    set_weight(0, 1);
    fill(0, 4);
    pcyc.delete(); c = 0;
    while (c < 40 && pcyc.size() < 4) begin tick(); c++; if (s_rd[0]) pcyc.push_back(cyc); end
    n_checks++;
    if (pcyc.size() != 4) begin n_fail++; $display("FAIL w1_pops: got %0d want 4", pcyc.size()); end
    for (int j = 1; j < pcyc.size(); j++) begin
      n_checks++;
      if (pcyc[j] - pcyc[j-1] != 2) begin n_fail++; $display("FAIL w1_gap[%0d]: got %0d want 2", j, pcyc[j] - pcyc[j-1]); end
    end
  endtask

  task automatic test_random();
    bit had_pop;
    int h_id, c;
    cla_irl_meta_type h_meta;
    for (int it = 0; it < 8; it++) begin
      do_reset();
      req_en = N'($urandom) | N'(1 << (it % N));
      for (int i = 0; i < N; i++) begin
        set_weight(i, int'($urandom_range(0, 15)));
        fill(i, int'($urandom_range(0, 6)));
      end
      run_model(0, req_en);
      had_pop = 1'b0; c = 0;
      while (c < 600 && got_src.size() < exp_src.size()) begin
        out_ready = ($urandom_range(0, 9) < 7);
        tick(); c++;
        n_checks++;
        if (!$onehot0(s_rd) || (s_rd & s_empty) != '0) begin
          n_fail++; $display("FAIL rnd_rd[%0d]: rd=%b empty=%b want one-hot-or-zero on non-empty", it, s_rd, s_empty);
        end
        if (had_pop) begin
          n_checks++;
          if (s_valid !== 1'b1 || int'(s_src) !== h_id || s_meta !== h_meta) begin
            n_fail++; $display("FAIL rnd_latency[%0d]: valid=%b src=%0d meta=%h want 1/%0d/%h", it, s_valid, s_src, s_meta, h_id, h_meta);
          end
        end
        had_pop = p_valid; h_id = p_id; h_meta = p_meta;
      end
      out_ready = 1'b1;
      repeat (4) tick();
      n_checks++;
      if (got_src.size() != exp_src.size()) begin n_fail++; $display("FAIL rnd_count[%0d]: got %0d want %0d", it, got_src.size(), exp_src.size()); end
      for (int j = 0; j < got_src.size() && j < exp_src.size(); j++) begin
        n_checks++;
        if (got_src[j] !== exp_src[j] || got_meta[j] !== exp_meta[j]) begin
          n_fail++; $display("FAIL rnd_order[%0d][%0d]: got src=%0d meta=%h want src=%0d meta=%h", it, j, got_src[j], got_meta[j], exp_src[j], exp_meta[j]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_weighted();
    test_stall();
    test_en_drop();
    test_weight0();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
